// File: rtl/steer_angle_scheduler.sv
// steer_angle_scheduler: sequences target-angle moves for the swerve wheel
// modules. Commands are held per wheel as PENDING, granted round-robin while
// fewer than MAX_ACTIVE wheels are rotating, and each granted wheel's
// angle-to-PWM controller is pulsed with angle_update. The wheel then waits in
// ACTIVE for angle_done or a timeout.
// Optional build macro: SCHED_SKIP_IN_TOL_EN -- a granted wheel whose target is
// already within TOLERANCE of its encoder angle returns to IDLE without a move.
module steer_angle_scheduler #(
    parameter int NUM_WHEELS     = 4,
    parameter int MAX_ACTIVE     = 2,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int TOLERANCE      = 20
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_wheel,
    input  logic [11:0]                cmd_angle,
    output logic                       cmd_ready,
    input  logic [NUM_WHEELS*12-1:0]   wheel_current_angle,
    input  logic [NUM_WHEELS-1:0]      wheel_angle_done,
    output logic [NUM_WHEELS*12-1:0]   wheel_target_angle,
    output logic [NUM_WHEELS-1:0]      wheel_angle_update,
    output logic [NUM_WHEELS-1:0]      wheel_busy,
    output logic [NUM_WHEELS-1:0]      wheel_timeout,
    input  logic                       status_clear,
    output logic                       all_done
);

    localparam int ANGLE_W = 12;
    localparam int PTR_W   = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_ACTIVE  = 2'd2
    } state_t;

    state_t                               state_q [NUM_WHEELS];
    state_t                               state_d [NUM_WHEELS];
    logic [TIMEOUT_W-1:0]                 timer_q [NUM_WHEELS];
    logic [TIMEOUT_W-1:0]                 timer_d [NUM_WHEELS];
    logic [NUM_WHEELS-1:0][ANGLE_W-1:0]   target_q, target_d;
    logic [NUM_WHEELS-1:0]                update_q, update_d;
    logic [NUM_WHEELS-1:0]                timeout_q, timeout_d;
    logic [PTR_W-1:0]                     rr_q, rr_d;

    int                                   active_cnt;
    logic                                 grant_vld;
    logic [PTR_W-1:0]                     grant_idx;
    logic [PTR_W-1:0]                     slot;
    logic                                 grant_skip;
    logic [PTR_W-1:0]                     cmd_idx;
    logic                                 cmd_accept;
    logic [NUM_WHEELS-1:0]                new_timeout;

    assign cmd_idx = PTR_W'(cmd_wheel);

    // Count rotating wheels and pick the first PENDING wheel from the rr pointer.
    always_comb begin
        active_cnt = 0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        slot       = '0;
        for (int i = 0; i < NUM_WHEELS; i++) begin
            if (state_q[i] == S_ACTIVE) begin
                active_cnt = active_cnt + 1;
            end
        end
        for (int k = 0; k < NUM_WHEELS; k++) begin
            slot = PTR_W'((int'(rr_q) + k) % NUM_WHEELS);
            if (!grant_vld && state_q[slot] == S_PENDING) begin
                grant_vld = 1'b1;
                grant_idx = slot;
            end
        end
        // A slot freed by a wheel finishing this cycle only counts next cycle.
        if (active_cnt >= MAX_ACTIVE) begin
            grant_vld = 1'b0;
        end
    end

`ifdef SCHED_SKIP_IN_TOL_EN
    logic [ANGLE_W-1:0] grant_cur;
    logic [ANGLE_W-1:0] grant_tgt;
    logic [ANGLE_W-1:0] grant_mag;

    // Plain unsigned distance (no wrap-around) between target and encoder angle.
    always_comb begin
        grant_cur  = wheel_current_angle[int'(grant_idx)*ANGLE_W +: ANGLE_W];
        grant_tgt  = target_q[grant_idx];
        grant_mag  = (grant_tgt >= grant_cur) ? (grant_tgt - grant_cur) : (grant_cur - grant_tgt);
        grant_skip = (int'(grant_mag) <= TOLERANCE);
    end
`else
    logic unused_current_angle;
    assign unused_current_angle = ^wheel_current_angle;
    assign grant_skip = 1'b0;
`endif

    // A wheel being granted this cycle cannot take a new target.
    always_comb begin
        cmd_ready = 1'b0;
        if (state_q[cmd_idx] == S_IDLE) begin
            cmd_ready = 1'b1;
        end else if (state_q[cmd_idx] == S_PENDING && !(grant_vld && grant_idx == cmd_idx)) begin
            cmd_ready = 1'b1;
        end
        cmd_accept = cmd_valid && cmd_ready;
    end

    // Per-wheel next state, target latch, timer, update pulse and timeout flags.
    always_comb begin
        new_timeout = '0;
        update_d    = '0;
        target_d    = target_q;
        for (int i = 0; i < NUM_WHEELS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (cmd_accept && cmd_idx == PTR_W'(i)) begin
                        state_d[i]  = S_PENDING;
                        target_d[i] = cmd_angle;
                    end
                end
                S_PENDING: begin
                    if (grant_vld && grant_idx == PTR_W'(i)) begin
                        if (grant_skip) begin
                            state_d[i] = S_IDLE;
                        end else begin
                            state_d[i]  = S_ACTIVE;
                            timer_d[i]  = '0;
                            update_d[i] = 1'b1;
                        end
                    end else if (cmd_accept && cmd_idx == PTR_W'(i)) begin
                        target_d[i] = cmd_angle;
                    end
                end
                S_ACTIVE: begin
                    if (wheel_angle_done[i]) begin
                        state_d[i] = S_IDLE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d[i]     = S_IDLE;
                        timer_d[i]     = '0;
                        new_timeout[i] = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
        if (grant_vld) begin
            rr_d = (grant_idx == PTR_W'(NUM_WHEELS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else begin
            rr_d = rr_q;
        end
        // A timeout arriving with status_clear must not be lost.
        timeout_d = (timeout_q & ~{NUM_WHEELS{status_clear}}) | new_timeout;
    end

    // State registers; reset returns every wheel to IDLE with cleared outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_WHEELS; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
            end
            target_q  <= '0;
            update_q  <= '0;
            timeout_q <= '0;
            rr_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_WHEELS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            target_q  <= target_d;
            update_q  <= update_d;
            timeout_q <= timeout_d;
            rr_q      <= rr_d;
        end
    end

    // Status outputs derived from the registered wheel states.
    always_comb begin
        wheel_busy = '0;
        for (int i = 0; i < NUM_WHEELS; i++) begin
            wheel_busy[i] = (state_q[i] != S_IDLE);
        end
        all_done = ~|wheel_busy;
    end

    assign wheel_target_angle = target_q;
    assign wheel_angle_update = update_q;
    assign wheel_timeout      = timeout_q;

endmodule

// File: tb/tb_steer_angle_scheduler.sv
// tb_steer_angle_scheduler: directed table-driven bench for the wheel move
// scheduler (TIMEOUT_CYCLES=100, MAX_ACTIVE=2), plus hand-written sequences
// for timeout, in-tolerance skip and mid-move reset.
module tb_steer_angle_scheduler;

    localparam int NW = 4;
    localparam int TO = 100;
`ifdef SCHED_SKIP_IN_TOL_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic [1:0]     cmd_wheel;
    logic [11:0]    cmd_angle;
    logic           cmd_ready;
    logic [NW*12-1:0] wheel_current_angle;
    logic [NW-1:0]  wheel_angle_done;
    logic [NW*12-1:0] wheel_target_angle;
    logic [NW-1:0]  wheel_angle_update;
    logic [NW-1:0]  wheel_busy;
    logic [NW-1:0]  wheel_timeout;
    logic           status_clear;
    logic           all_done;

    always #5 clock = ~clock;

    steer_angle_scheduler #(
        .NUM_WHEELS(NW), .MAX_ACTIVE(2), .TIMEOUT_W(24),
        .TIMEOUT_CYCLES(TO), .TOLERANCE(20)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_wheel(cmd_wheel), .cmd_angle(cmd_angle),
        .cmd_ready(cmd_ready),
        .wheel_current_angle(wheel_current_angle),
        .wheel_angle_done(wheel_angle_done),
        .wheel_target_angle(wheel_target_angle),
        .wheel_angle_update(wheel_angle_update),
        .wheel_busy(wheel_busy), .wheel_timeout(wheel_timeout),
        .status_clear(status_clear), .all_done(all_done)
    );

    typedef struct {
        logic        cv;
        logic [1:0]  w;
        logic [11:0] a;
        logic [3:0]  done;
        logic        exp_ready;
        logic [3:0]  exp_busy;
        logic [3:0]  exp_upd;
        logic [1:0]  tw;
        logic [11:0] exp_tgt;
    } vec_t;

    vec_t vecs [13];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        cmd_valid        = 1'b0;
        cmd_wheel        = 2'd0;
        cmd_angle        = 12'd0;
        wheel_angle_done = '0;
        status_clear     = 1'b0;
    endtask

    task automatic send(input logic [1:0] w, input logic [11:0] a);
        idle_in();
        cmd_valid = 1'b1;
        cmd_wheel = w;
        cmd_angle = a;
        tick();
        idle_in();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 12'd100, 4'b0000, 1'b1, 4'b0001, 4'b0000, 2'd0, 12'd100};
        vecs[1]  = '{1'b1, 2'd1, 12'd200, 4'b0000, 1'b1, 4'b0011, 4'b0001, 2'd1, 12'd200};
        vecs[2]  = '{1'b1, 2'd2, 12'd300, 4'b0000, 1'b1, 4'b0111, 4'b0010, 2'd2, 12'd300};
        vecs[3]  = '{1'b1, 2'd3, 12'd400, 4'b0000, 1'b1, 4'b1111, 4'b0000, 2'd3, 12'd400};
        vecs[4]  = '{1'b1, 2'd1, 12'd500, 4'b0000, 1'b0, 4'b1111, 4'b0000, 2'd1, 12'd200};
        vecs[5]  = '{1'b1, 2'd3, 12'd500, 4'b0000, 1'b1, 4'b1111, 4'b0000, 2'd3, 12'd500};
        vecs[6]  = '{1'b0, 2'd0, 12'd0,   4'b0001, 1'b0, 4'b1110, 4'b0000, 2'd0, 12'd100};
        vecs[7]  = '{1'b0, 2'd2, 12'd0,   4'b0000, 1'b0, 4'b1110, 4'b0100, 2'd2, 12'd300};
        vecs[8]  = '{1'b0, 2'd0, 12'd0,   4'b0010, 1'b1, 4'b1100, 4'b0000, 2'd1, 12'd200};
        vecs[9]  = '{1'b0, 2'd0, 12'd0,   4'b0000, 1'b1, 4'b1100, 4'b1000, 2'd3, 12'd500};
        vecs[10] = '{1'b0, 2'd0, 12'd0,   4'b0000, 1'b1, 4'b1100, 4'b0000, 2'd3, 12'd500};
        vecs[11] = '{1'b0, 2'd0, 12'd0,   4'b1100, 1'b1, 4'b0000, 4'b0000, 2'd0, 12'd100};
        vecs[12] = '{1'b0, 2'd0, 12'd0,   4'b0001, 1'b1, 4'b0000, 4'b0000, 2'd0, 12'd100};

        wheel_current_angle = '0;
        wheel_current_angle[2*12 +: 12] = 12'd1000;
        idle_in();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_all_done", 48'(all_done), 48'd1);
        chk("rst_busy", 48'(wheel_busy), 48'd0);
        chk("rst_update", 48'(wheel_angle_update), 48'd0);
        chk("rst_targets", wheel_target_angle, 48'd0);
        chk("rst_timeout", 48'(wheel_timeout), 48'd0);
        reset = 1'b0;

        // Table: grant order, slot limit, busy-wheel rejection, pending overwrite
        for (int i = 0; i < 13; i++) begin
            cmd_valid        = vecs[i].cv;
            cmd_wheel        = vecs[i].w;
            cmd_angle        = vecs[i].a;
            wheel_angle_done = vecs[i].done;
            #1;
            chk($sformatf("v%0d_ready", i), 48'(cmd_ready), 48'(vecs[i].exp_ready));
            tick();
            chk($sformatf("v%0d_busy", i), 48'(wheel_busy), 48'(vecs[i].exp_busy));
            chk($sformatf("v%0d_update", i), 48'(wheel_angle_update), 48'(vecs[i].exp_upd));
            chk($sformatf("v%0d_target", i), 48'(wheel_target_angle[vecs[i].tw*12 +: 12]), 48'(vecs[i].exp_tgt));
            chk($sformatf("v%0d_all_done", i), 48'(all_done), 48'(vecs[i].exp_busy == 4'b0000));
        end
        idle_in();

        // Timeout: no done for wheel 0; flag appears 100 cycles after grant
        send(2'd0, 12'd7);
        tick();
        chk("to_update", 48'(wheel_angle_update), 48'b0001);
        for (int c = 0; c < TO - 1; c++) tick();
        chk("to_busy_c99", 48'(wheel_busy[0]), 48'd1);
        chk("to_flag_c99", 48'(wheel_timeout), 48'd0);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        chk("to_busy_c100", 48'(wheel_busy[0]), 48'd0);
        chk("to_flag_set_wins", 48'(wheel_timeout), 48'b0001);
        tick();
        chk("to_flag_sticky", 48'(wheel_timeout), 48'b0001);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        chk("to_flag_cleared", 48'(wheel_timeout), 48'd0);

        // Done on the last allowed cycle beats the timeout
        send(2'd0, 12'd8);
        tick();
        for (int c = 0; c < TO - 1; c++) tick();
        chk("d99_busy_before", 48'(wheel_busy[0]), 48'd1);
        wheel_angle_done = 4'b0001;
        tick();
        wheel_angle_done = '0;
        chk("d99_busy_after", 48'(wheel_busy[0]), 48'd0);
        chk("d99_no_flag", 48'(wheel_timeout), 48'd0);

        // In-tolerance target (|1015-1000| = 15)
        send(2'd2, 12'd1015);
        chk("tol_pending", 48'(wheel_busy), 48'b0100);
        tick();
        chk("tol_update", 48'(wheel_angle_update), SKIP_EN ? 48'd0 : 48'b0100);
        chk("tol_busy", 48'(wheel_busy), SKIP_EN ? 48'd0 : 48'b0100);
        wheel_angle_done = 4'b0100;
        tick();
        wheel_angle_done = '0;
        chk("tol_idle", 48'(wheel_busy), 48'd0);

        // Out-of-tolerance target (|1021-1000| = 21) always moves
        send(2'd2, 12'd1021);
        tick();
        chk("otol_update", 48'(wheel_angle_update), 48'b0100);
        chk("otol_target", 48'(wheel_target_angle[2*12 +: 12]), 48'd1021);
        tick();
        chk("otol_single_pulse", 48'(wheel_angle_update), 48'd0);
        wheel_angle_done = 4'b0100;
        tick();
        wheel_angle_done = '0;
        chk("otol_idle", 48'(wheel_busy), 48'd0);

        // Reset while two wheels are rotating
        send(2'd0, 12'd11);
        send(2'd1, 12'd22);
        tick();
        chk("mr_busy", 48'(wheel_busy), 48'b0011);
        chk("mr_update", 48'(wheel_angle_update), 48'b0010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_all_done", 48'(all_done), 48'd1);
        chk("mr_busy_clr", 48'(wheel_busy), 48'd0);
        chk("mr_update_clr", 48'(wheel_angle_update), 48'd0);
        chk("mr_targets", wheel_target_angle, 48'd0);
        tick();
        chk("mr_no_update", 48'(wheel_angle_update), 48'd0);
        chk("mr_still_idle", 48'(wheel_busy), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
